// File: rtl/csrbank11.sv
// csrbank11: Unibus CSR bank shared between a PDP-11 and an ARM host.
// Define CSRBANK11_WRFIFO_EN to log PDP writes in a FIFO instead of a sticky written[] bitmap.
module csrbank11 #(
  parameter logic [17:0]               ADDR    = 18'o774510,
  parameter logic [7:0]                INTVEC  = 8'o120,
  parameter int                        NREGL2  = 2,
  parameter logic [16*(1<<NREGL2)-1:0] RWMASK  = '1,
  parameter logic [16*(1<<NREGL2)-1:0] W1CMASK = '0,
  parameter int                        FIFOL2  = 3
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        armwrite,
  input  logic [3:0]  armraddr,
  input  logic [3:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  output logic        armintrq,
  output logic        intreq,
  output logic [7:0]  irvec,
  input  logic        intgnt,
  input  logic [7:0]  igvec,
  input  logic [17:0] a_in_h,
  input  logic [1:0]  c_in_h,
  input  logic [15:0] d_in_h,
  input  logic        init_in_h,
  input  logic        msyn_in_h,
  output logic [15:0] d_out_h,
  output logic        ssyn_out_h
);
  localparam int NREG = 1 << NREGL2;

  logic              enable, irqlvl, level_q;
  logic [15:0]       regs [NREG];
  logic              sel, pdp_wr, hi, lo;
  logic [NREGL2-1:0] idx;
  logic [15:0]       bmask, w1c_bits, rw_bits, wr_value;
  logic [3:0]        arm_widx, arm_ridx;
  logic              arm_reg_wr, arm_reg_rd, arm_ctl_wr, arm_log_wr;
  logic [31:0]       stat_word, log_word;

  assign irvec = INTVEC;

  // An ARM write in the same clock blocks selection, so the PDP cycle simply starts a clock later.
  assign sel    = enable & msyn_in_h & ~ssyn_out_h & ~armwrite &
                  (a_in_h[17:NREGL2+1] == ADDR[17:NREGL2+1]);
  assign idx    = a_in_h[NREGL2:1];
  assign pdp_wr = sel & c_in_h[1];
  assign hi     = ~c_in_h[0] | a_in_h[0];
  assign lo     = ~c_in_h[0] | ~a_in_h[0];
  assign bmask  = {{8{hi}}, {8{lo}}};

  assign w1c_bits = W1CMASK[{idx, 4'b0} +: 16] & bmask;
  assign rw_bits  = RWMASK[{idx, 4'b0} +: 16] & ~W1CMASK[{idx, 4'b0} +: 16] & bmask;
  assign wr_value = (regs[idx] & ~(w1c_bits & d_in_h) & ~rw_bits) | (d_in_h & rw_bits);

  assign arm_widx   = armwaddr - 4'd4;
  assign arm_ridx   = armraddr - 4'd4;
  assign arm_reg_wr = armwrite & (armwaddr >= 4'd4) & (arm_widx < 4'(NREG));
  assign arm_reg_rd = (armraddr >= 4'd4) & (arm_ridx < 4'(NREG));
  assign arm_ctl_wr = armwrite & (armwaddr == 4'd1);
  assign arm_log_wr = armwrite & (armwaddr == 4'd2);

  always_ff @(posedge CLOCK) begin
    if (RESET || init_in_h) begin
      if (RESET)
        enable <= 1'b0;
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
      irqlvl     <= 1'b0;
      level_q    <= 1'b0;
      intreq     <= 1'b0;
      d_out_h    <= '0;
      ssyn_out_h <= 1'b0;
    end else begin
      level_q <= irqlvl & enable;
      if (irqlvl && enable && !level_q)
        intreq <= 1'b1;
      else if (intgnt && (igvec == INTVEC))
        intreq <= 1'b0;

      if (arm_ctl_wr) begin
        enable <= armwdata[31];
        irqlvl <= armwdata[1];
      end
      if (arm_reg_wr)
        regs[arm_widx[NREGL2-1:0]] <= (regs[arm_widx[NREGL2-1:0]] & ~armwdata[31:16]) |
                                      (armwdata[15:0] & armwdata[31:16]);

      if (sel) begin
        ssyn_out_h <= 1'b1;
        if (c_in_h[1])
          regs[idx] <= wr_value;
        else
          d_out_h <= regs[idx];
      end else if (ssyn_out_h && !msyn_in_h) begin
        ssyn_out_h <= 1'b0;
        d_out_h    <= '0;
      end
    end
  end

`ifdef CSRBANK11_WRFIFO_EN
  localparam int DEPTH = 1 << FIFOL2;

  logic [20:0]     mem [DEPTH];
  logic [FIFOL2:0] wptr, rptr, count;
  logic            ovf, empty, pop, push_ok;

  assign count   = wptr - rptr;
  assign empty   = (count == '0);
  assign pop     = arm_log_wr & ~empty;
  // A pop in the same clock frees the slot, so a push into a full FIFO still fits.
  assign push_ok = pdp_wr & (~count[FIFOL2] | pop);

  always_ff @(posedge CLOCK) begin
    if (push_ok)
      mem[wptr[FIFOL2-1:0]] <= {hi, lo, 3'(idx), d_in_h};
  end

  always_ff @(posedge CLOCK) begin
    if (RESET || init_in_h) begin
      wptr <= '0;
      rptr <= '0;
      ovf  <= 1'b0;
    end else begin
      if (pop)
        rptr <= rptr + 1'b1;
      if (push_ok)
        wptr <= wptr + 1'b1;
      if (pdp_wr && !push_ok)
        ovf <= 1'b1;
      else if (arm_ctl_wr && armwdata[2])
        ovf <= 1'b0;
    end
  end

  assign stat_word = {enable, 14'b0, ovf, 16'(count)};
  assign log_word  = empty ? '0 : {1'b1, 10'b0, mem[rptr[FIFOL2-1:0]]};
  assign armintrq  = ~empty | ovf;
`else
  logic [NREG-1:0] written;
  logic            unused_fifol2;

  assign unused_fifol2 = (FIFOL2 > 0);

  always_ff @(posedge CLOCK) begin
    if (RESET || init_in_h) begin
      written <= '0;
    end else begin
      if (arm_log_wr)
        written <= written & ~armwdata[NREG-1:0];
      if (pdp_wr)
        written[idx] <= 1'b1;
    end
  end

  assign stat_word = {enable, 31'b0};
  assign log_word  = 32'(written);
  assign armintrq  = |written;
`endif

  always_comb begin
    armrdata = '0;
    case (armraddr)
      4'd0:    armrdata = {16'h4342, 4'(NREGL2), 12'h001};
      4'd1:    armrdata = stat_word;
      4'd2:    armrdata = log_word;
      4'd3:    armrdata = {enable, 5'b0, INTVEC, ADDR};
      default: if (arm_reg_rd) armrdata = {16'b0, regs[arm_ridx[NREGL2-1:0]]};
    endcase
  end
endmodule

// File: tb/tb_csrbank11.sv
// tb_csrbank11: self-checking bench for csrbank11 against a cycle-level behavioural model;
// follows whichever build (CSRBANK11_WRFIFO_EN defined or not) the design was compiled with.
module tb_csrbank11;
  localparam logic [17:0] ADDR    = 18'o774510;
  localparam logic [7:0]  INTVEC  = 8'o120;
  localparam int          NREGL2  = 2;
  localparam int          NREG    = 4;
  localparam int          FIFOL2  = 1;
  localparam logic [63:0] RWMASK  = 64'hFFFF_0FF0_7FFF_00FF;
  localparam logic [63:0] W1CMASK = 64'h0000_F00F_0000_FF00;

  logic        CLOCK, RESET;
  logic        armwrite;
  logic [3:0]  armraddr, armwaddr;
  logic [31:0] armwdata, armrdata;
  logic        armintrq, intreq, intgnt;
  logic [7:0]  irvec, igvec;
  logic [17:0] a_in_h;
  logic [1:0]  c_in_h;
  logic [15:0] d_in_h, d_out_h;
  logic        init_in_h, msyn_in_h, ssyn_out_h;

  int checks = 0;
  int errors = 0;

  csrbank11 #(
    .ADDR(ADDR), .INTVEC(INTVEC), .NREGL2(NREGL2),
    .RWMASK(RWMASK), .W1CMASK(W1CMASK), .FIFOL2(FIFOL2)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .armwrite(armwrite), .armraddr(armraddr), .armwaddr(armwaddr),
    .armwdata(armwdata), .armrdata(armrdata), .armintrq(armintrq),
    .intreq(intreq), .irvec(irvec), .intgnt(intgnt), .igvec(igvec),
    .a_in_h(a_in_h), .c_in_h(c_in_h), .d_in_h(d_in_h),
    .init_in_h(init_in_h), .msyn_in_h(msyn_in_h),
    .d_out_h(d_out_h), .ssyn_out_h(ssyn_out_h)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Reference state: what the bank must hold, kept as plain arrays and a queue.
  logic            m_enable = 1'b0, m_irqlvl = 1'b0, m_level_was = 1'b0;
  logic            m_intreq = 1'b0, m_ssyn = 1'b0, m_ovf = 1'b0;
  logic [15:0]     m_dout = '0;
  logic [15:0]     m_regs [NREG];
  logic [20:0]     m_log [$];
  logic [NREG-1:0] m_written = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] exp_rdata(input logic [3:0] r);
    int ri;
    ri = int'(r) - 4;
    if (r == 4'd0) return 32'h4342_0001 + (32'(NREGL2) << 12);
`ifdef CSRBANK11_WRFIFO_EN
    if (r == 4'd1) return (32'(m_enable) << 31) | (32'(m_ovf) << 16) | 32'(m_log.size());
    if (r == 4'd2) return (m_log.size() > 0) ? ((32'd1 << 31) | 32'(m_log[0])) : 32'd0;
`else
    if (r == 4'd1) return 32'(m_enable) << 31;
    if (r == 4'd2) return 32'(m_written);
`endif
    if (r == 4'd3) return (32'(m_enable) << 31) | (32'(INTVEC) << 18) | 32'(ADDR);
    if (ri >= 0 && ri < NREG) return 32'(m_regs[ri]);
    return 32'd0;
  endfunction

  function automatic logic exp_armintrq();
`ifdef CSRBANK11_WRFIFO_EN
    return (m_log.size() > 0) || m_ovf;
`else
    return m_written != '0;
`endif
  endfunction

  // Advance the reference by one clock using the inputs present at the edge.
  always @(posedge CLOCK) begin : model
    logic sel_now, level_now, bhi, blo, byte_on;
    int   ri, wi;
    sel_now = m_enable && msyn_in_h && !m_ssyn && !armwrite && (a_in_h[17:3] == ADDR[17:3]);
    ri = int'(a_in_h[2:1]);
    if (RESET || init_in_h) begin
      if (RESET) m_enable = 1'b0;
      for (int k = 0; k < NREG; k++) m_regs[k] = '0;
      m_irqlvl = 1'b0; m_level_was = 1'b0; m_intreq = 1'b0;
      m_ssyn = 1'b0; m_dout = '0; m_ovf = 1'b0; m_written = '0;
      m_log.delete();
    end else begin
      level_now = m_irqlvl && m_enable;
      if (level_now && !m_level_was) m_intreq = 1'b1;
      else if (intgnt && igvec == INTVEC) m_intreq = 1'b0;
      m_level_was = level_now;
      if (armwrite) begin
        wi = int'(armwaddr) - 4;
        if (armwaddr == 4'd1) begin
          m_enable = armwdata[31];
          m_irqlvl = armwdata[1];
          if (armwdata[2]) m_ovf = 1'b0;
        end else if (armwaddr == 4'd2) begin
          if (m_log.size() > 0) void'(m_log.pop_front());
          m_written = m_written & ~armwdata[NREG-1:0];
        end else if (wi >= 0 && wi < NREG) begin
          for (int b = 0; b < 16; b++)
            if (armwdata[16+b]) m_regs[wi][b] = armwdata[b];
        end
      end
      if (sel_now) begin
        m_ssyn = 1'b1;
        if (c_in_h[1]) begin
          bhi = !c_in_h[0] || a_in_h[0];
          blo = !c_in_h[0] || !a_in_h[0];
          for (int b = 0; b < 16; b++) begin
            byte_on = (b >= 8) ? bhi : blo;
            if (byte_on && W1CMASK[16*ri+b]) begin
              if (d_in_h[b]) m_regs[ri][b] = 1'b0;
            end else if (byte_on && RWMASK[16*ri+b]) begin
              m_regs[ri][b] = d_in_h[b];
            end
          end
          if (m_log.size() < (1 << FIFOL2)) m_log.push_back({bhi, blo, 3'(ri), d_in_h});
          else m_ovf = 1'b1;
          m_written[ri] = 1'b1;
        end else begin
          m_dout = m_regs[ri];
        end
      end else if (m_ssyn && !msyn_in_h) begin
        m_ssyn = 1'b0;
        m_dout = '0;
      end
    end
  end

  // Every cycle, once both model and DUT have settled after the edge.
  always @(posedge CLOCK) begin
    #1;
    checkOutput("ssyn", 32'(ssyn_out_h), 32'(m_ssyn));
    checkOutput("d_out", 32'(d_out_h), 32'(m_dout));
    checkOutput("intreq", 32'(intreq), 32'(m_intreq));
    checkOutput("armintrq", 32'(armintrq), 32'(exp_armintrq()));
    checkOutput("armrdata", armrdata, exp_rdata(armraddr));
    checkOutput("irvec", 32'(irvec), 32'(INTVEC));
  end

  task automatic arm_write(input logic [3:0] idx, input logic [31:0] data);
    armwaddr = idx; armwdata = data; armwrite = 1'b1;
    @(negedge CLOCK);
    armwrite = 1'b0;
  endtask

  task automatic arm_read(input logic [3:0] idx, output logic [31:0] v);
    armraddr = idx;
    #1;
    v = armrdata;
  endtask

  task automatic pdp(input logic [17:0] addr, input logic wr, input logic byt,
                     input logic [15:0] data, output logic [15:0] rd, output int lat);
    a_in_h = addr; c_in_h = {wr, byt}; d_in_h = data; msyn_in_h = 1'b1; lat = 0;
    do begin
      @(negedge CLOCK);
      lat++;
    end while (!ssyn_out_h && lat < 8);
    if (!ssyn_out_h) checkOutput("ssyn_timeout", 32'(ssyn_out_h), 32'd1);
    rd = d_out_h;
    msyn_in_h = 1'b0;
    @(negedge CLOCK);
  endtask

  task automatic applyStimulus();
    armwrite  = ($urandom_range(0, 3) == 0);
    armwaddr  = 4'($urandom_range(0, 9));
    armwdata  = $urandom;
    if (armwaddr == 4'd1 && $urandom_range(0, 7) != 0) armwdata[31] = 1'b1;
    armraddr  = 4'($urandom_range(0, 15));
    msyn_in_h = ($urandom_range(0, 3) != 0);
    a_in_h    = ($urandom_range(0, 3) != 0) ? ADDR + 18'($urandom_range(0, 7)) : 18'($urandom);
    c_in_h    = 2'($urandom);
    d_in_h    = 16'($urandom);
    intgnt    = ($urandom_range(0, 3) == 0);
    igvec     = ($urandom_range(0, 1) == 0) ? INTVEC : 8'($urandom);
    init_in_h = ($urandom_range(0, 63) == 0);
    @(negedge CLOCK);
  endtask

  initial begin : stim
    logic [31:0] v;
    logic [15:0] rd;
    int          lat;
    RESET = 1'b1; armwrite = 1'b0; armraddr = '0; armwaddr = '0; armwdata = '0;
    intgnt = 1'b0; igvec = '0; a_in_h = '0; c_in_h = '0; d_in_h = '0;
    init_in_h = 1'b0; msyn_in_h = 1'b0;
    repeat (3) @(negedge CLOCK);
    checkOutput("rst_ssyn", 32'(ssyn_out_h), 32'd0);
    checkOutput("rst_intreq", 32'(intreq), 32'd0);
    arm_read(4'd1, v); checkOutput("rst_status", v, 32'd0);
    arm_read(4'd0, v); checkOutput("id_word", v, 32'h4342_2001);
    RESET = 1'b0;
    @(negedge CLOCK);

    arm_write(4'd1, 32'h8000_0000);
    arm_read(4'd3, v); checkOutput("cfg_word", v, 32'h8143_F948);

    arm_write(4'd5, {16'hFFFF, 16'o123456});
    pdp(ADDR + 18'd2, 1'b0, 1'b0, 16'h0, rd, lat);
    checkOutput("rd_latency", 32'(lat), 32'd1);
    checkOutput("rd_data", 32'(rd), 32'(16'o123456));
    checkOutput("rd_end_ssyn", 32'(ssyn_out_h), 32'd0);
    checkOutput("rd_end_dout", 32'(d_out_h), 32'd0);

    arm_write(4'd4, 32'hFFFF_F000);
    pdp(ADDR, 1'b1, 1'b0, 16'h30AA, rd, lat);
    checkOutput("wr_latency", 32'(lat), 32'd1);
    arm_read(4'd4, v); checkOutput("w1c_rw_mix", v, 32'h0000_C0AA);

    init_in_h = 1'b1;
    @(negedge CLOCK);
    init_in_h = 1'b0;
    arm_read(4'd1, v); checkOutput("init_status", v, 32'h8000_0000);
    arm_read(4'd4, v); checkOutput("init_reg0", v, 32'd0);

    pdp(ADDR + 18'd5, 1'b1, 1'b1, 16'hFF00, rd, lat);
    arm_read(4'd2, v);
`ifdef CSRBANK11_WRFIFO_EN
    checkOutput("log_head", v, 32'h8012_FF00);
`else
    checkOutput("log_bitmap", v, 32'h0000_0004);
`endif
    checkOutput("log_armintrq", 32'(armintrq), 32'd1);
    arm_read(4'd6, v); checkOutput("byte_hi_reg2", v, 32'h0000_0F00);
    arm_write(4'd2, 32'h0000_00FF);
    arm_read(4'd2, v); checkOutput("log_popped", v, 32'd0);
    checkOutput("pop_armintrq", 32'(armintrq), 32'd0);

    for (int i = 0; i < 5; i++) begin
      pdp(ADDR + 18'd6, 1'b1, 1'b0, 16'(i + 1), rd, lat);
      checkOutput("full_latency", 32'(lat), 32'd1);
    end
    arm_read(4'd1, v);
`ifdef CSRBANK11_WRFIFO_EN
    checkOutput("ovf_status", v, 32'h8001_0002);
`else
    checkOutput("ovf_status", v, 32'h8000_0000);
`endif
    arm_write(4'd1, 32'h8000_0004);
    arm_read(4'd1, v);
`ifdef CSRBANK11_WRFIFO_EN
    checkOutput("ovf_cleared", v, 32'h8000_0002);
`else
    checkOutput("ovf_cleared", v, 32'h8000_0000);
`endif
    checkOutput("full_armintrq", 32'(armintrq), 32'd1);
    arm_write(4'd2, 32'h0000_00FF);
    arm_write(4'd2, 32'h0000_00FF);
    checkOutput("drain_armintrq", 32'(armintrq), 32'd0);

    arm_write(4'd1, 32'h8000_0002);
    checkOutput("irq_not_yet", 32'(intreq), 32'd0);
    @(negedge CLOCK);
    checkOutput("irq_raised", 32'(intreq), 32'd1);
    intgnt = 1'b1; igvec = 8'o121;
    @(negedge CLOCK);
    checkOutput("irq_wrong_vec", 32'(intreq), 32'd1);
    igvec = INTVEC;
    @(negedge CLOCK);
    intgnt = 1'b0;
    checkOutput("irq_granted", 32'(intreq), 32'd0);
    repeat (5) @(negedge CLOCK);
    checkOutput("irq_held_level", 32'(intreq), 32'd0);
    arm_write(4'd1, 32'h8000_0000);

    a_in_h = ADDR + 18'd2; c_in_h = 2'b00; msyn_in_h = 1'b1;
    arm_write(4'd5, 32'hFFFF_1234);
    checkOutput("defer_ssyn_low", 32'(ssyn_out_h), 32'd0);
    @(negedge CLOCK);
    checkOutput("defer_ssyn_high", 32'(ssyn_out_h), 32'd1);
    checkOutput("defer_data", 32'(d_out_h), 32'h0000_1234);
    msyn_in_h = 1'b0;
    @(negedge CLOCK);

    a_in_h = ADDR; msyn_in_h = 1'b1;
    @(negedge CLOCK);
    checkOutput("init_cycle_ssyn", 32'(ssyn_out_h), 32'd1);
    init_in_h = 1'b1;
    @(negedge CLOCK);
    checkOutput("init_abort_ssyn", 32'(ssyn_out_h), 32'd0);
    init_in_h = 1'b0; msyn_in_h = 1'b0;
    arm_read(4'd1, v); checkOutput("init_keeps_enable", v & 32'h8000_0000, 32'h8000_0000);
    @(negedge CLOCK);

    repeat (600) applyStimulus();

    armwrite = 1'b0; msyn_in_h = 1'b0; intgnt = 1'b0; init_in_h = 1'b0;
    repeat (4) @(negedge CLOCK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
